// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and requester identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_CPU,
        BUSY_DMA
    } arb_state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_DMA
    } req_id_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: flags a memory access that has gone TIMEOUT cycles without an ack.
// TIMEOUT = 0 disables the watchdog entirely.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    // Saturates at LAST so the counter never wraps while an expiry is pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (busy && !ack && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (TIMEOUT > 0) && busy && !ack && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the unified MIPS memory between the CPU and a DMA/debug loader.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise the CPU has fixed priority.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_err,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    import mem_arb_pkg::*;

    arb_state_t state;
    arb_state_t state_next;
    req_id_t    last_grant;
    req_id_t    last_grant_next;
    logic       load;
    logic       grant_dma;
    logic       expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= REQ_DMA;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        load            = 1'b0;
        grant_dma       = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    load = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    grant_dma = dma_req && (!cpu_req || (last_grant == REQ_CPU));
`else
                    grant_dma = !cpu_req;
`endif
                    state_next = grant_dma ? BUSY_DMA : BUSY_CPU;
                end
            end
            BUSY_CPU: begin
                if (mem_ack || expire) begin
                    state_next      = IDLE;
                    last_grant_next = REQ_CPU;
                end
            end
            BUSY_DMA: begin
                if (mem_ack || expire) begin
                    state_next      = IDLE;
                    last_grant_next = REQ_DMA;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory-side registers hold the winner's command for the whole access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_dma ? dma_we : cpu_we;
            mem_addr  <= grant_dma ? dma_addr : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
        end else if ((state != IDLE) && (mem_ack || expire)) begin
            mem_req <= 1'b0;
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .start (load),
        .busy  (state != IDLE),
        .ack   (mem_ack),
        .expire(expire)
    );

    assign cpu_ack   = mem_ack && (state == BUSY_CPU);
    assign dma_ack   = mem_ack && (state == BUSY_DMA);
    assign cpu_err   = expire && (state == BUSY_CPU);
    assign dma_err   = expire && (state == BUSY_DMA);
    assign cpu_rdata = cpu_ack ? mem_rdata : '0;
    assign dma_rdata = dma_ack ? mem_rdata : '0;
    assign cpu_stall = cpu_req && !cpu_ack && !cpu_err;

endmodule
